safe_lock_ctrl: RTL and testbench

Parametrised serial unlock controller for the digital safe lock. It receives a serial bit stream qualified by `ser_val` and compares a full `CODE_LEN`-bit code word against the stored code. It issues a single-cycle verdict only after the last bit, so a wrong bit is never revealed early. It counts consecutive failures and enforces a timed lockout. It also aborts an entry that stalls for too long. It sits between the keypad/serial front end and the latch actuator.

---
 rtl/safe_lock_pkg.sv | 25 ++
 rtl/safe_lock_timer.sv | 45 ++++
 rtl/safe_lock_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_safe_lock_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/safe_lock_pkg.sv
// -----------------------------------------------------------------------------
// safe_lock_pkg
// Shared types and default constants for the serial safe lock controller.
//   lock_state_e        : controller state encoding (IDLE, COLLECT, UNLOCK,
//                         FAIL, LOCKOUT)
//   DEF_*               : default parameter values used by safe_lock_ctrl
// Optional feature macro used by the controller: SAFE_LOCK_PROG_EN
// -----------------------------------------------------------------------------
package safe_lock_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        UNLOCK  = 3'd2,
        FAIL    = 3'd3,
        LOCKOUT = 3'd4
    } lock_state_e;

    localparam int unsigned DEF_CODE_LEN       = 4;
    localparam logic [3:0]  DEF_CODE           = 4'b1011;
    localparam int unsigned DEF_MAX_TRIES      = 3;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32;

endpackage

// File: rtl/safe_lock_timer.sv
// -----------------------------------------------------------------------------
// safe_lock_timer
// Loadable down-counter. A load makes the counter hold CYCLES; it then counts
// down once per clock and rests at zero. expired_o is high during the last
// counted cycle (count == 1), so a consumer that leaves its state on
// expired_o stays exactly CYCLES cycles after the load edge.
// Ports:
//   clk       in  system clock (rising edge)
//   rst       in  asynchronous active-high reset
//   load_i    in  reload the counter with CYCLES at this edge
//   expired_o out last cycle of the counted interval
// -----------------------------------------------------------------------------
module safe_lock_timer #(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic expired_o
);

    localparam int unsigned W = $clog2(CYCLES + 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = W'(CYCLES);
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == W'(1));

endmodule

// File: rtl/safe_lock_ctrl.sv
// -----------------------------------------------------------------------------
// safe_lock_ctrl
// Serial unlock controller. Collects a CODE_LEN-bit code MSB first, gives a
// one-cycle verdict only after the last bit, counts consecutive failures,
// enforces a timed lockout and aborts entries that stall.
// Ports:
//   clk          in   system clock (rising edge)
//   rst          in   asynchronous active-high reset
//   ser_val      in   serial bit valid
//   ser_data     in   serial code bit
//   code_wr      in   code write strobe        (SAFE_LOCK_PROG_EN only)
//   code_in      in   new code, CODE_LEN bits  (SAFE_LOCK_PROG_EN only)
//   output_val   out  verdict strobe (one cycle)
//   output_data  out  verdict: 1 = unlock, 0 = wrong code / timeout
//   locked       out  high for the whole lockout period
//   fail_count   out  consecutive failure count
// Macro SAFE_LOCK_PROG_EN: when defined, the code lives in a register that can
// be rewritten once after each successful unlock.
// -----------------------------------------------------------------------------
module safe_lock_ctrl
    import safe_lock_pkg::*;
#(
    parameter int unsigned         CODE_LEN       = DEF_CODE_LEN,
    parameter logic [CODE_LEN-1:0] CODE           = CODE_LEN'(DEF_CODE),
    parameter int unsigned         MAX_TRIES      = DEF_MAX_TRIES,
    parameter int unsigned         LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int unsigned         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ser_val,
    input  logic                             ser_data,
`ifdef SAFE_LOCK_PROG_EN
    input  logic                             code_wr,
    input  logic [CODE_LEN-1:0]              code_in,
`endif
    output logic                             output_val,
    output logic                             output_data,
    output logic                             locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

    localparam int unsigned IDX_W = $clog2(CODE_LEN);
    localparam int unsigned FC_W  = $clog2(MAX_TRIES + 1);

    lock_state_e         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                mism_q, mism_d;
    logic [FC_W-1:0]     fc_q, fc_d;
    logic [FC_W-1:0]     fc_inc;
    logic [CODE_LEN-1:0] code_cur;
    logic [CODE_LEN-1:0] code_rev;
    logic [IDX_W-1:0]    cmp_idx;
    logic                bit_mis;
    logic                to_load, to_expired;
    logic                lo_load, lo_expired;

    // Bit-reversed copy so that received bit k lines up with code_rev[k].
    generate
        for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_rev
            assign code_rev[gi] = code_cur[CODE_LEN-1-gi];
        end
    endgenerate

    // idx_q keeps its last value after an entry, so IDLE always compares bit 0.
    assign cmp_idx = (state_q == COLLECT) ? idx_q : '0;
    assign bit_mis = ser_data ^ code_rev[cmp_idx];
    assign fc_inc  = (fc_q == FC_W'(MAX_TRIES)) ? fc_q : fc_q + 1'b1;

    safe_lock_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .load_i    (to_load),
        .expired_o (to_expired)
    );

    safe_lock_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lockout (
        .clk       (clk),
        .rst       (rst),
        .load_i    (lo_load),
        .expired_o (lo_expired)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mism_d  = mism_q;
        fc_d    = fc_q;
        to_load = 1'b0;
        lo_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ser_val) begin
                    idx_d   = IDX_W'(1);
                    mism_d  = bit_mis;
                    to_load = 1'b1;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                // An arriving bit takes priority over a timeout on the same edge.
                if (ser_val) begin
                    to_load = 1'b1;
                    mism_d  = mism_q | bit_mis;
                    if (idx_q == IDX_W'(CODE_LEN - 1)) begin
                        if (mism_q | bit_mis) begin
                            state_d = FAIL;
                            fc_d    = fc_inc;
                        end else begin
                            state_d = UNLOCK;
                            fc_d    = '0;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (to_expired) begin
                    state_d = FAIL;
                    fc_d    = fc_inc;
                end
            end
            UNLOCK: begin
                state_d = IDLE;
            end
            FAIL: begin
                if (fc_q == FC_W'(MAX_TRIES)) begin
                    state_d = LOCKOUT;
                    lo_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (lo_expired) begin
                    state_d = IDLE;
                    fc_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mism_q  <= 1'b0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mism_q  <= mism_d;
            fc_q    <= fc_d;
        end
    end

`ifdef SAFE_LOCK_PROG_EN
    logic [CODE_LEN-1:0] code_q, code_d;
    logic                armed_q, armed_d;
    logic                accept;

    assign accept = ser_val && ((state_q == IDLE) || (state_q == COLLECT));

    // A rewrite is only honoured in IDLE right after a successful unlock.
    always_comb begin
        code_d  = code_q;
        armed_d = armed_q;
        if (state_q == UNLOCK) begin
            armed_d = 1'b1;
        end else if (accept) begin
            armed_d = 1'b0;
        end
        if (code_wr && armed_q && (state_q == IDLE)) begin
            code_d  = code_in;
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q  <= CODE;
            armed_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            armed_q <= armed_d;
        end
    end

    assign code_cur = code_q;
`else
    assign code_cur = CODE;
`endif

    assign output_val  = (state_q == UNLOCK) || (state_q == FAIL);
    assign output_data = (state_q == UNLOCK);
    assign locked      = (state_q == LOCKOUT);
    assign fail_count  = fc_q;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_safe_lock_ctrl
// Directed bench for safe_lock_ctrl with default parameters (code 1011,
// 3 tries, 16-cycle lockout, 32-cycle timeout). A vector table covers basic
// entries; hand-written sequences cover lockout, timeout, async reset and,
// when SAFE_LOCK_PROG_EN is defined, code reprogramming.
// -----------------------------------------------------------------------------
module tb_safe_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser_val = 1'b0;
    logic       ser_data = 1'b0;
    logic       output_val;
    logic       output_data;
    logic       locked;
    logic [1:0] fail_count;
`ifdef SAFE_LOCK_PROG_EN
    logic       code_wr = 1'b0;
    logic [3:0] code_in = 4'b0000;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    safe_lock_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ser_val     (ser_val),
        .ser_data    (ser_data),
`ifdef SAFE_LOCK_PROG_EN
        .code_wr     (code_wr),
        .code_in     (code_in),
`endif
        .output_val  (output_val),
        .output_data (output_data),
        .locked      (locked),
        .fail_count  (fail_count)
    );

    typedef struct {
        logic       v;
        logic       d;
        logic       ev;
        logic       ed;
        logic       el;
        logic [1:0] efc;
    } vec_t;

    vec_t vecs[31];

    // Present inputs for the next rising edge, then sample 1 time unit after it.
    task automatic tick(input logic v, input logic d);
        ser_val  = v;
        ser_data = d;
        @(posedge clk);
        #1;
    endtask

    // output_data is only compared while a verdict is expected.
    task automatic check(input string name, input logic ev, input logic ed,
                         input logic el, input logic [1:0] efc);
        n_cmp++;
        if (output_val !== ev || (ev && output_data !== ed) ||
            locked !== el || fail_count !== efc) begin
            n_bad++;
            $display("FAIL %s: got val=%0b data=%0b locked=%0b fc=%0d, want val=%0b data=%0b locked=%0b fc=%0d",
                     name, output_val, output_data, locked, fail_count, ev, ed, el, efc);
        end else begin
            $display("ok   %s: val=%0b data=%0b locked=%0b fc=%0d",
                     name, output_val, output_data, locked, fail_count);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ser_val  = 1'b0;
        ser_data = 1'b0;
`ifdef SAFE_LOCK_PROG_EN
        code_wr  = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", 1'b0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
    endtask

    // Send a 4-bit code MSB first; no strobe until the last bit.
    task automatic send4(input string name, input logic [3:0] c,
                         input logic ev, input logic ed,
                         input logic [1:0] fc_before, input logic [1:0] fc_after);
        for (int i = 3; i >= 1; i--) begin
            tick(1'b1, c[i]);
            check(name, 1'b0, 1'b0, 1'b0, fc_before);
        end
        tick(1'b1, c[0]);
        check(name, ev, ed, 1'b0, fc_after);
    endtask

    initial begin
        logic [3:0] good;
        good = 4'b1011;

        //            v     d     ev    ed    el    efc
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}; // data w/o valid ignored
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0}; // 1011 unlocks
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}; // dropped in UNLOCK
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1}; // 0011 fails
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1}; // dropped in FAIL
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0}; // unlock clears count
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1}; // 1111 fails (bit 1)
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[23] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[24] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2}; // 1010 fails (last bit)
        vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[26] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[27] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[28] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[29] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[30] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

        // ---------------- table-driven vectors ----------------
        do_reset();
        for (int i = 0; i < 31; i++) begin
            tick(vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].efc);
        end

        // ---------------- lockout ----------------
        do_reset();
        send4("wrong1", 4'b0000, 1'b1, 1'b0, 2'd0, 2'd1);
        tick(1'b0, 1'b0);
        check("wrong1_idle", 1'b0, 1'b0, 1'b0, 2'd1);
        send4("wrong2", 4'b0100, 1'b1, 1'b0, 2'd1, 2'd2);
        tick(1'b0, 1'b0);
        check("wrong2_idle", 1'b0, 1'b0, 1'b0, 2'd2);
        send4("wrong3", 4'b1001, 1'b1, 1'b0, 2'd2, 2'd3);
        // Keep sending the right code; all of it must be dropped.
        for (int k = 0; k < 16; k++) begin
            tick(1'b1, good[3 - (k % 4)]);
            check($sformatf("lockout%0d", k), 1'b0, 1'b0, 1'b1, 2'd3);
        end
        tick(1'b0, 1'b0);
        check("lockout_end", 1'b0, 1'b0, 1'b0, 2'd0);
        send4("after_lockout", good, 1'b1, 1'b1, 2'd0, 2'd0);

        // ---------------- timeout fires ----------------
        do_reset();
        tick(1'b1, 1'b1);
        check("to_bit0", 1'b0, 1'b0, 1'b0, 2'd0);
        tick(1'b1, 1'b0);
        check("to_bit1", 1'b0, 1'b0, 1'b0, 2'd0);
        for (int k = 1; k <= 31; k++) begin
            tick(1'b0, 1'b0);
            check($sformatf("to_gap%0d", k), 1'b0, 1'b0, 1'b0, 2'd0);
        end
        tick(1'b0, 1'b0);
        check("to_gap32_fail", 1'b1, 1'b0, 1'b0, 2'd1);
        tick(1'b0, 1'b0);
        check("to_after", 1'b0, 1'b0, 1'b0, 2'd1);

        // ---------------- bit on the timeout edge wins ----------------
        do_reset();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        for (int k = 1; k <= 31; k++) begin
            tick(1'b0, 1'b0);
        end
        check("race_gap31", 1'b0, 1'b0, 1'b0, 2'd0);
        tick(1'b1, 1'b1);
        check("race_bit_wins", 1'b0, 1'b0, 1'b0, 2'd0);
        tick(1'b1, 1'b1);
        check("race_unlock", 1'b1, 1'b1, 1'b0, 2'd0);

        // ---------------- asynchronous reset mid-entry ----------------
        do_reset();
        send4("pre_rst1", 4'b0000, 1'b1, 1'b0, 2'd0, 2'd1);
        tick(1'b0, 1'b0);
        send4("pre_rst2", 4'b1111, 1'b1, 1'b0, 2'd1, 2'd2);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        check("mid_entry", 1'b0, 1'b0, 1'b0, 2'd2);
        ser_val = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst", 1'b0, 1'b0, 1'b0, 2'd0);
        #2 rst = 1'b0;
        send4("post_rst", good, 1'b1, 1'b1, 2'd0, 2'd0);

`ifdef SAFE_LOCK_PROG_EN
        // ---------------- programmable code ----------------
        do_reset();
        code_in = 4'b0000;
        code_wr = 1'b1;
        tick(1'b0, 1'b0);
        code_wr = 1'b0;
        check("wr_unarmed", 1'b0, 1'b0, 1'b0, 2'd0);
        send4("old_code_kept", good, 1'b1, 1'b1, 2'd0, 2'd0);
        tick(1'b0, 1'b0);
        code_in = 4'b0110;
        code_wr = 1'b1;
        tick(1'b0, 1'b0);
        code_wr = 1'b0;
        check("wr_armed", 1'b0, 1'b0, 1'b0, 2'd0);
        send4("old_code_fails", good, 1'b1, 1'b0, 2'd0, 2'd1);
        tick(1'b0, 1'b0);
        send4("new_code_unlocks", 4'b0110, 1'b1, 1'b1, 2'd1, 2'd0);
`endif

        tick(1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
